// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with a registered one-hot grant, bounded hold time and
// a mandatory dead cycle between grants.
module rr_grant_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ID_W     = 2,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               gnt_valid_o,
  output logic [ID_W-1:0]    gnt_id_o,
  output logic               timeout_o
);

  localparam int unsigned CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic        HOLD_EN = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               gnt_valid_q, gnt_valid_d;
  logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
  logic               timeout_q, timeout_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;

  logic               win_found_c;
  logic [ID_W-1:0]    win_id_c;
  logic               still_req_c;
  logic [ID_W-1:0]    ptr_next_c;

  // First set request at or above ptr wins; otherwise the lowest set request below ptr.
  always_comb begin
    win_found_c = 1'b0;
    win_id_c    = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (!win_found_c && req_i[j] && (ID_W'(j) >= ptr_q)) begin
        win_found_c = 1'b1;
        win_id_c    = ID_W'(j);
      end
    end
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (!win_found_c && req_i[j]) begin
        win_found_c = 1'b1;
        win_id_c    = ID_W'(j);
      end
    end
  end

  assign still_req_c = |(req_i & gnt_q);
  assign ptr_next_c  = (gnt_id_q == LAST_ID) ? '0 : gnt_id_q + ID_W'(1);

  always_comb begin
    state_d     = state_q;
    gnt_d       = '0;
    gnt_valid_d = 1'b0;
    gnt_id_d    = gnt_id_q;
    timeout_d   = 1'b0;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;

    case (state_q)
      ST_IDLE, ST_GAP: begin
        if (win_found_c) begin
          gnt_d       = NUM_REQ'(1) << win_id_c;
          gnt_valid_d = 1'b1;
          gnt_id_d    = win_id_c;
          hold_cnt_d  = '0;
          state_d     = ST_GRANT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (!still_req_c) begin
          ptr_d   = ptr_next_c;
          state_d = ST_GAP;
        end else if (HOLD_EN && (hold_cnt_q == HOLD_LAST)) begin
          ptr_d     = ptr_next_c;
          timeout_d = 1'b1;
          state_d   = ST_GAP;
        end else begin
          gnt_d       = gnt_q;
          gnt_valid_d = 1'b1;
          // Saturates instead of wrapping when hold time is unlimited.
          if (hold_cnt_q != '1) begin
            hold_cnt_d = hold_cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        gnt_id_d = '0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
      timeout_q   <= 1'b0;
      ptr_q       <= '0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_id_q    <= gnt_id_d;
      timeout_q   <= timeout_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_valid_o = gnt_valid_q;
  assign gnt_id_o    = gnt_id_q;
  assign timeout_o   = timeout_q;

endmodule

// File: doc/rr_grant_arbiter.md
Name: rr_grant_arbiter

Overview:
- Round-robin arbiter sharing one resource among NUM_REQ requesters with a registered one-hot grant.
- A requester holds its req line for as long as it needs the resource; the grant is released on req drop or after a bounded hold time.
- After every release there is one dead cycle before the next grant, so the resource always sees a clean turnaround.
- Sits in front of any shared datapath slot (bus port, memory bank, shared FSM resource) that currently has fixed-priority grant logic.

Parameters:
- NUM_REQ, 4: number of requesters, minimum 2.
- ID_W, 2: width of gnt_id. Must be at least clog2(NUM_REQ).
- MAX_HOLD, 16: maximum number of consecutive cycles gnt may stay high for one requester. 0 means unlimited (no preemption).

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  request vector; bit i high means requester i wants or is using the resource.
- gnt  output  NUM_REQ  registered one-hot grant, or all zero.
- gnt_valid  output  1  registered; high exactly when gnt is non-zero.
- gnt_id  output  ID_W  index of the current or most recent grantee; holds its value while gnt_valid is 0.
- timeout  output  1  one-cycle pulse, high in the dead cycle that follows a forced (MAX_HOLD) release.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, gnt=0, gnt_valid=0, gnt_id=0, timeout=0.
  - Priority pointer ptr=0, hold_cnt=0.
  - Reset overrides everything, including mid-grant: at the first edge with reset high, gnt drops to 0.
- Arbitration function, evaluated combinationally in IDLE and GAP:
  - Scan req starting at index ptr, upward, wrapping modulo NUM_REQ.
  - The first set bit wins.
- IDLE:
  - If req is non-zero at an edge: gnt=onehot(winner), gnt_valid=1, gnt_id=winner, hold_cnt=0, state=GRANT. Grant latency is one edge after req is sampled high.
  - Otherwise stay in IDLE.
- GRANT (hold_cnt counts completed grant cycles, starting at 0):
  - If req[gnt_id]==0 at an edge (voluntary release):
    - gnt=0, gnt_valid=0, ptr=(gnt_id+1) mod NUM_REQ, state=GAP, timeout stays 0.
  - Else if MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 (forced release):
    - Same actions as a voluntary release, plus timeout=1 for the GAP cycle.
    - With req held constant, gnt is therefore high for exactly MAX_HOLD cycles.
  - Else hold_cnt increments; the counter saturates and does not wrap when MAX_HOLD=0.
  - req bits of all non-granted requesters are ignored during GRANT.
- GAP (exactly one cycle with gnt=0):
  - Arbitrate on req using the updated ptr.
  - If any req is set: grant at the next edge exactly as from IDLE, state=GRANT.
  - Otherwise state=IDLE.
  - timeout returns to 0 at the edge leaving GAP.
- Fairness:
  - A preempted requester that keeps req high is served again only after every other active requester has had a turn.
  - If it is the only requester, it is re-granted immediately after the GAP cycle.
- Boundaries:
  - ptr wraps from NUM_REQ-1 to 0.
  - A req that rises in the same cycle as another requester's release competes in GAP using the new ptr.
  - An encoding of state outside IDLE/GRANT/GAP goes to IDLE with all outputs cleared at the next edge.
- Invariants:
  - gnt is never multi-hot.
  - gnt_valid equals the OR-reduction of gnt.
  - gnt never goes from one requester directly to another without a zero cycle in between.

Test Plan:
All scenarios use NUM_REQ=4 and MAX_HOLD=4.
- Reset: hold reset 3 cycles with req=4'b1111 -> gnt=0, gnt_valid=0, gnt_id=0, timeout=0 throughout. First edge after reset deasserts -> gnt=4'b0001, gnt_id=0.
- Single requester: req=4'b0100 from cycle 0 -> gnt=4'b0100, gnt_id=2 after the first edge. Drop req after 2 grant cycles -> gnt=0 next edge, timeout=0, then IDLE.
- Round-robin preemption: req=4'b1111 held constant -> grant order 0,1,2,3,0. Each grant lasts 4 cycles, followed by 1 gap cycle with timeout=1.
- Wrap/pointer: after a grant to id 3 is released, ptr=0. With req=4'b1010, the next grant is id 1; after its release, ptr=2 and the next grant is id 3.
- Lone requester timeout: req=4'b0001 held 12 cycles -> gnt high for 4 cycles, gap 1 cycle with timeout=1, gnt high again for 4 cycles. gnt_id=0 throughout.
- Reset mid-grant: during a grant to id 2, pulse reset for 1 cycle with req=4'b1111 -> gnt=0 at that edge, ptr reset. The first grant after reset is id 0.
